// File: rtl/frame_tx_pkg.sv
// Shared sizing constants and index helper for the LED frame transmitter.
package frame_tx_pkg;
    localparam int FRAME_W  = 24;
    localparam int N_LEDS   = 8;
    localparam int IDX_W    = 3;
    localparam int BITCNT_W = 5;

    localparam logic [BITCNT_W-1:0] BITS_PER_FRAME = BITCNT_W'(FRAME_W);
    localparam logic [BITCNT_W-1:0] LAST_BIT       = BITCNT_W'(FRAME_W - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX       = IDX_W'(N_LEDS - 1);

    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction
endpackage

// File: rtl/frame_shifter.sv
// 24-bit MSB-first load/shift register with a saturating bit counter.
module frame_shifter
    import frame_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               load,
    input  logic               shift,
    input  logic [FRAME_W-1:0] load_data,
    output logic               msb,
    output logic               shift_accepted,
    output logic               all_bits_shifted
);
    logic [FRAME_W-1:0]  shift_reg;
    logic [BITCNT_W-1:0] count_reg;
    logic                done_reg;

    // Once the counter saturates, further shift requests are ignored.
    assign shift_accepted   = shift && (count_reg != BITS_PER_FRAME);
    assign msb              = shift_reg[FRAME_W-1];
    assign all_bits_shifted = done_reg;

    // Reset reloads the shifter too, so the first bit is valid straight out of reset.
    always_ff @(posedge clk) begin
        if (!rstn || load) begin
            shift_reg <= load_data;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else if (shift_accepted) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
            count_reg <= count_reg + 1'b1;
            done_reg  <= (count_reg == LAST_BIT);
        end
    end
endmodule

// File: rtl/frame_transmitter.sv
// Serialises an 8-frame LED colour set bit by bit; tracks frame index and
// raises a set request when the index wraps back to LED 0.
module frame_transmitter
    import frame_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               new_frame_rqst,
    input  logic               new_bit_rqst,
    input  logic [FRAME_W-1:0] frame_for_led0,
    input  logic [FRAME_W-1:0] frame_for_led1,
    input  logic [FRAME_W-1:0] frame_for_led2,
    input  logic [FRAME_W-1:0] frame_for_led3,
    input  logic [FRAME_W-1:0] frame_for_led4,
    input  logic [FRAME_W-1:0] frame_for_led5,
    input  logic [FRAME_W-1:0] frame_for_led6,
    input  logic [FRAME_W-1:0] frame_for_led7,
    output logic               all_bits_shifted,
    output logic               bit_to_transmit,
    output logic               new_frames_set_rqst,
    output logic [FRAME_W-1:0] frame_to_transmit_dbg,
    output logic [IDX_W-1:0]   no_of_frame_dbg
);
    logic [FRAME_W-1:0] frame_arr [N_LEDS];
    logic [IDX_W-1:0]   idx_reg;
    logic [IDX_W-1:0]   idx_next;
    logic [FRAME_W-1:0] load_frame;
    logic [FRAME_W-1:0] dbg_reg;
    logic               set_rqst_reg;
    logic               bit_accepted;

    assign frame_arr[0] = frame_for_led0;
    assign frame_arr[1] = frame_for_led1;
    assign frame_arr[2] = frame_for_led2;
    assign frame_arr[3] = frame_for_led3;
    assign frame_arr[4] = frame_for_led4;
    assign frame_arr[5] = frame_for_led5;
    assign frame_arr[6] = frame_for_led6;
    assign frame_arr[7] = frame_for_led7;

    // During reset the shifter must pick up LED 0 rather than idx_reg+1.
    assign idx_next   = rstn ? next_index(idx_reg) : '0;
    assign load_frame = frame_arr[idx_next];

    frame_shifter u_shifter (
        .clk              (clk),
        .rstn             (rstn),
        .load             (new_frame_rqst),
        .shift            (new_bit_rqst),
        .load_data        (load_frame),
        .msb              (bit_to_transmit),
        .shift_accepted   (bit_accepted),
        .all_bits_shifted (all_bits_shifted)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx_reg      <= '0;
            dbg_reg      <= frame_arr[0];
            set_rqst_reg <= 1'b0;
        end else if (new_frame_rqst) begin
            idx_reg      <= idx_next;
            dbg_reg      <= load_frame;
            set_rqst_reg <= (idx_reg == LAST_IDX);
        end else if (bit_accepted) begin
            set_rqst_reg <= 1'b0;
        end
    end

    assign new_frames_set_rqst   = set_rqst_reg;
    assign frame_to_transmit_dbg = dbg_reg;
    assign no_of_frame_dbg       = idx_reg;
endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter: reset, bit streams, frame loop, priority, reset.
module tb_frame_transmitter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        new_frame_rqst;
    logic        new_bit_rqst;
    logic [23:0] led [8];
    logic        all_bits_shifted;
    logic        bit_to_transmit;
    logic        new_frames_set_rqst;
    logic [23:0] frame_to_transmit_dbg;
    logic [2:0]  no_of_frame_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_transmitter dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .new_frame_rqst        (new_frame_rqst),
        .new_bit_rqst          (new_bit_rqst),
        .frame_for_led0        (led[0]),
        .frame_for_led1        (led[1]),
        .frame_for_led2        (led[2]),
        .frame_for_led3        (led[3]),
        .frame_for_led4        (led[4]),
        .frame_for_led5        (led[5]),
        .frame_for_led6        (led[6]),
        .frame_for_led7        (led[7]),
        .all_bits_shifted      (all_bits_shifted),
        .bit_to_transmit       (bit_to_transmit),
        .new_frames_set_rqst   (new_frames_set_rqst),
        .frame_to_transmit_dbg (frame_to_transmit_dbg),
        .no_of_frame_dbg       (no_of_frame_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_req();
        new_bit_rqst = 1'b1;
        tick();
        new_bit_rqst = 1'b0;
    endtask

    task automatic frame_req();
        new_frame_rqst = 1'b1;
        tick();
        new_frame_rqst = 1'b0;
    endtask

    logic [23:0] exp_frame [8];
    logic        exp_first [8];

    initial begin
        exp_frame[0] = 24'h111111; exp_frame[1] = 24'hBBBBBB;
        exp_frame[2] = 24'h444444; exp_frame[3] = 24'h888888;
        exp_frame[4] = 24'h999999; exp_frame[5] = 24'hAAAAAA;
        exp_frame[6] = 24'hCCCCCC; exp_frame[7] = 24'h222222;
        // MSB of each frame, worked out by hand from the hex digit.
        exp_first[0] = 0; exp_first[1] = 1; exp_first[2] = 0; exp_first[3] = 1;
        exp_first[4] = 1; exp_first[5] = 1; exp_first[6] = 1; exp_first[7] = 0;
        for (int k = 0; k < 8; k++) led[k] = exp_frame[k];

        rstn = 1'b0; new_frame_rqst = 1'b0; new_bit_rqst = 1'b0;
        tick(); tick();
        check("rst_bit", 32'(bit_to_transmit), 32'd0);
        check("rst_idx", 32'(no_of_frame_dbg), 32'd0);
        check("rst_dbg", 32'(frame_to_transmit_dbg), 32'h111111);
        check("rst_allbits", 32'(all_bits_shifted), 32'd0);
        check("rst_setrq", 32'(new_frames_set_rqst), 32'd0);
        rstn = 1'b1;
        tick();

        // LED 0 = 0x111111 -> 0001 repeated
        for (int i = 0; i < 24; i++) begin
            check($sformatf("f0_bit%0d", i), 32'(bit_to_transmit), 32'((i % 4) == 3));
            if (i == 23) check("f0_allbits_23", 32'(all_bits_shifted), 32'd0);
            bit_req();
        end
        check("f0_allbits", 32'(all_bits_shifted), 32'd1);
        check("f0_bit_end", 32'(bit_to_transmit), 32'd0);
        bit_req();
        check("f0_25th_all", 32'(all_bits_shifted), 32'd1);
        check("f0_25th_bit", 32'(bit_to_transmit), 32'd0);
        check("f0_25th_idx", 32'(no_of_frame_dbg), 32'd0);

        // LED 1 = 0xBBBBBB -> 1011 repeated
        frame_req();
        check("f1_idx", 32'(no_of_frame_dbg), 32'd1);
        check("f1_dbg", 32'(frame_to_transmit_dbg), 32'hBBBBBB);
        check("f1_allbits", 32'(all_bits_shifted), 32'd0);
        for (int i = 0; i < 24; i++) begin
            check($sformatf("f1_bit%0d", i), 32'(bit_to_transmit), 32'((i % 4) != 1));
            bit_req();
        end
        check("f1_allbits_end", 32'(all_bits_shifted), 32'd1);

        for (int k = 2; k < 8; k++) begin
            frame_req();
            check($sformatf("loop_idx%0d", k), 32'(no_of_frame_dbg), 32'(k));
            check($sformatf("loop_dbg%0d", k), 32'(frame_to_transmit_dbg), 32'(exp_frame[k]));
            check($sformatf("loop_bit%0d", k), 32'(bit_to_transmit), 32'(exp_first[k]));
            check($sformatf("loop_setrq%0d", k), 32'(new_frames_set_rqst), 32'd0);
        end
        frame_req();
        check("wrap_idx", 32'(no_of_frame_dbg), 32'd0);
        check("wrap_setrq", 32'(new_frames_set_rqst), 32'd1);
        check("wrap_dbg", 32'(frame_to_transmit_dbg), 32'h111111);
        tick();
        check("wrap_hold", 32'(new_frames_set_rqst), 32'd1);
        bit_req();
        check("wrap_clear", 32'(new_frames_set_rqst), 32'd0);
        check("wrap_bit1", 32'(bit_to_transmit), 32'd0);

        // Frame load wins over a simultaneous bit request mid-frame.
        bit_req(); bit_req();
        check("mid_bit3", 32'(bit_to_transmit), 32'd1);
        new_bit_rqst = 1'b1; new_frame_rqst = 1'b1;
        tick();
        new_bit_rqst = 1'b0; new_frame_rqst = 1'b0;
        check("both_idx", 32'(no_of_frame_dbg), 32'd1);
        check("both_dbg", 32'(frame_to_transmit_dbg), 32'hBBBBBB);
        check("both_bit0", 32'(bit_to_transmit), 32'd1);
        check("both_allbits", 32'(all_bits_shifted), 32'd0);
        bit_req();
        check("both_bit1", 32'(bit_to_transmit), 32'd0);

        // Wrap again so the flag is set, then reset mid-frame.
        for (int k = 0; k < 7; k++) frame_req();
        check("wrap2_idx", 32'(no_of_frame_dbg), 32'd0);
        check("wrap2_setrq", 32'(new_frames_set_rqst), 32'd1);
        frame_req(); bit_req();
        rstn = 1'b0;
        tick();
        check("rst2_bit", 32'(bit_to_transmit), 32'd0);
        check("rst2_idx", 32'(no_of_frame_dbg), 32'd0);
        check("rst2_dbg", 32'(frame_to_transmit_dbg), 32'h111111);
        check("rst2_allbits", 32'(all_bits_shifted), 32'd0);
        check("rst2_setrq", 32'(new_frames_set_rqst), 32'd0);
        rstn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
